// File: rtl/sd_crc_pkg.sv
// sd_crc_pkg: shared mode encoding, polynomials, widths and FSM states for the SD CRC engine
package sd_crc_pkg;

    localparam logic        CRC_MODE_7  = 1'b0;
    localparam logic        CRC_MODE_16 = 1'b1;
    localparam int          CRC7_W      = 7;
    localparam int          CRC16_W     = 16;
    localparam logic [6:0]  CRC7_POLY   = 7'h09;
    localparam logic [15:0] CRC16_POLY  = 16'h1021;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_SHIFT, ST_DONE} state_t;

    // Index of the final serialised bit, loaded into the shift-out counter
    function automatic logic [3:0] last_index(input logic mode);
        return (mode == CRC_MODE_16) ? 4'(CRC16_W - 1) : 4'(CRC7_W - 1);
    endfunction

endpackage

// File: rtl/sd_crc_lane.sv
// sd_crc_lane: one CRC lane with LFSR accumulator and MSB-first shift-out register
module sd_crc_lane
    import sd_crc_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_mode,
    input  logic        i_bit_valid,
    input  logic        i_bit,
    input  logic        i_load,
    input  logic        i_shift,
    output logic [15:0] o_crc,
    output logic        o_msb
`ifdef SD_CRC_CHECK_EN
    ,
    output logic        o_nz
`endif
);

    logic [15:0] r_crc;
    logic [15:0] r_sh;
    logic [15:0] w_upd;
    logic [15:0] w_acc;
    logic        w_fb7;
    logic        w_fb16;

    // Next remainder for one payload bit; w_acc includes a bit arriving on the flush cycle
    always_comb begin
        w_fb7  = i_bit ^ r_crc[6];
        w_fb16 = i_bit ^ r_crc[15];
        w_upd  = (i_mode == CRC_MODE_16)
               ? ({r_crc[14:0], 1'b0} ^ (w_fb16 ? CRC16_POLY : 16'h0000))
               : {9'h000, {r_crc[5:0], 1'b0} ^ (w_fb7 ? CRC7_POLY : 7'h00)};
        w_acc  = i_bit_valid ? w_upd : r_crc;
    end

    // Accumulator and shift register; CRC7 is left-aligned on load so the MSB is always bit 15
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_crc <= '0;
            r_sh  <= '0;
        end else begin
            if (i_bit_valid)
                r_crc <= w_upd;
            if (i_load)
                r_sh <= (i_mode == CRC_MODE_16) ? w_acc : {w_acc[6:0], 9'h000};
            else if (i_shift)
                r_sh <= {r_sh[14:0], 1'b0};
        end
    end

    assign o_crc = r_crc;
    assign o_msb = r_sh[15];
`ifdef SD_CRC_CHECK_EN
    assign o_nz  = |w_acc;
`endif

endmodule

// File: rtl/sd_crc_engine.sv
// sd_crc_engine: multi-lane streaming CRC7/CRC16 generator-checker; SD_CRC_CHECK_EN enables crc_err
module sd_crc_engine
    import sd_crc_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_mode,
    input  logic                 i_bit_valid,
    input  logic [LANES-1:0]     i_bit_in,
    input  logic                 i_flush,
    input  logic                 i_out_ready,
    output logic                 o_busy,
    output logic [16*LANES-1:0]  o_crc,
    output logic                 o_crc_valid,
    output logic [LANES-1:0]     o_crc_bit,
    output logic                 o_crc_last,
    output logic                 o_crc_ready,
    output logic [LANES-1:0]     o_crc_err
);

    state_t     r_state;
    logic       r_mode;
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_valid;
    logic       r_last;
    logic       r_ready;
    logic       w_bv;
    logic       w_load;
    logic       w_shift;

    assign w_bv    = i_bit_valid & (r_state == ST_ACCUM) & ~i_start;
    assign w_load  = i_flush & (r_state == ST_ACCUM) & ~i_start;
    assign w_shift = i_out_ready & (r_state == ST_SHIFT) & ~i_start;

`ifdef SD_CRC_CHECK_EN
    logic [LANES-1:0] w_nz;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sd_crc_lane u_lane (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_clear     (i_start),
            .i_mode      (r_mode),
            .i_bit_valid (w_bv),
            .i_bit       (i_bit_in[l]),
            .i_load      (w_load),
            .i_shift     (w_shift),
            .o_crc       (o_crc[16*l +: 16]),
            .o_msb       (o_crc_bit[l])
`ifdef SD_CRC_CHECK_EN
            ,
            .o_nz        (w_nz[l])
`endif
        );
    end

    // Control FSM with registered status outputs; start overrides everything but reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_mode  <= CRC_MODE_7;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ready <= 1'b0;
        end else if (i_start) begin
            r_state <= ST_ACCUM;
            r_mode  <= i_mode;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (i_flush) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= last_index(r_mode);
                        r_valid <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (i_out_ready) begin
                        if (r_cnt == 4'd0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_ready <= 1'b1;
                        end else begin
                            r_cnt  <= r_cnt - 4'd1;
                            r_last <= (r_cnt == 4'd1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_crc_valid = r_valid;
    assign o_crc_last  = r_last;
    assign o_crc_ready = r_ready;

`ifdef SD_CRC_CHECK_EN
    logic [LANES-1:0] r_err;

    // Flag lanes whose final remainder (including any bit on the flush cycle) is nonzero
    always_ff @(posedge i_clk) begin
        if (i_reset || i_start)
            r_err <= '0;
        else if (w_load)
            r_err <= w_nz;
    end

    assign o_crc_err = r_err;
`else
    assign o_crc_err = '0;
`endif

endmodule
